// File: rtl/crpa_dly_pkg.sv
// Shared types and index helpers for the CRPA delay-line configuration path.
package crpa_dly_pkg;
  typedef enum logic [1:0] {IDLE, COPY, FLUSH} state_t;

  // Bit width needed to index n items, never less than 1.
  function automatic int clog2w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Flat entry index; delays_array uses the same mapping.
  function automatic int ent_idx(input int ch, input int tap, input int nt);
    return ch * nt + tap;
  endfunction
endpackage

// File: rtl/crpa_dly_table.sv
// Shadow delay register file: one write port, one asynchronous read port.
module crpa_dly_table #(
  parameter int N  = 32,
  parameter int W  = 5,
  parameter int AW = 5
) (
  input  logic          i_clk,
  input  logic          i_reset,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [W-1:0]  i_wdata,
  input  logic [AW-1:0] i_raddr,
  output logic [W-1:0]  o_rdata
);
  logic [W-1:0] r_mem [N];

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      for (int i = 0; i < N; i++) r_mem[i] <= '0;
    end else if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];
endmodule

// File: rtl/crpa_dly_ctrl.sv
// Delay configuration sequencer: shadow writes, atomic copy into the active
// table, and ena held low until the delay line has flushed with the new values.
module crpa_dly_ctrl
  import crpa_dly_pkg::*;
#(
  parameter  int Nin   = 8,
  parameter  int NT    = 4,
  parameter  int DLY_W = 5,
  localparam int NE    = Nin * NT,
  localparam int CH_W  = clog2w(Nin),
  localparam int TAP_W = clog2w(NT),
  localparam int IDX_W = clog2w(NE)
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_cfg_valid,
  output logic                  o_cfg_ready,
  input  logic [CH_W-1:0]       i_cfg_ch,
  input  logic [TAP_W-1:0]      i_cfg_tap,
  input  logic [DLY_W-1:0]      i_cfg_dly,
  input  logic                  i_commit,
  output logic [NE*DLY_W-1:0]   o_dly_active,
  output logic                  o_ena,
  output logic                  o_busy,
  output logic                  o_cfg_err,
  output logic                  o_commit_drop
);
  state_t           r_state;
  logic [IDX_W-1:0] r_idx;
  logic [DLY_W-1:0] r_maxd;
  logic [DLY_W:0]   r_fcnt;
  logic             r_ena, r_busy, r_ready, r_cfg_err, r_commit_drop;
  logic [DLY_W-1:0] r_active [NE];

  logic             w_acc, w_bad, w_ch_bad, w_tap_bad;
  logic [IDX_W-1:0] w_waddr;
  logic [DLY_W-1:0] w_rd, w_maxn;

  // Range checks only exist when the index field can encode illegal values.
  generate
    if ((1 << CH_W) == Nin) begin : g_ch_full
      assign w_ch_bad = 1'b0;
    end else begin : g_ch_chk
      assign w_ch_bad = (i_cfg_ch >= CH_W'(Nin));
    end
    if ((1 << TAP_W) == NT) begin : g_tap_full
      assign w_tap_bad = 1'b0;
    end else begin : g_tap_chk
      assign w_tap_bad = (i_cfg_tap >= TAP_W'(NT));
    end
  endgenerate

  assign w_bad   = w_ch_bad | w_tap_bad;
  assign w_acc   = i_cfg_valid & r_ready;
  assign w_waddr = IDX_W'(ent_idx(int'(i_cfg_ch), int'(i_cfg_tap), NT));
  assign w_maxn  = (w_rd > r_maxd) ? w_rd : r_maxd;

  crpa_dly_table #(.N(NE), .W(DLY_W), .AW(IDX_W)) u_shadow (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_we    (w_acc & ~w_bad),
    .i_waddr (w_waddr),
    .i_wdata (i_cfg_dly),
    .i_raddr (r_idx),
    .o_rdata (w_rd)
  );

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state       <= IDLE;
      r_idx         <= '0;
      r_maxd        <= '0;
      r_fcnt        <= '0;
      r_ena         <= 1'b1;
      r_busy        <= 1'b0;
      r_ready       <= 1'b1;
      r_cfg_err     <= 1'b0;
      r_commit_drop <= 1'b0;
      for (int i = 0; i < NE; i++) r_active[i] <= '0;
    end else begin
      r_cfg_err     <= w_acc & w_bad;
      r_commit_drop <= i_commit & (r_state != IDLE);
      case (r_state)
        IDLE: begin
          // Same-cycle write lands in the shadow on this edge, ahead of the copy.
          if (i_commit) begin
            r_state <= COPY;
            r_idx   <= '0;
            r_maxd  <= '0;
            r_ena   <= 1'b0;
            r_busy  <= 1'b1;
            r_ready <= 1'b0;
          end
        end
        COPY: begin
          r_active[r_idx] <= w_rd;
          r_maxd          <= w_maxn;
          r_idx           <= r_idx + IDX_W'(1);
          if (r_idx == IDX_W'(NE - 1)) begin
            r_state <= FLUSH;
            r_fcnt  <= {1'b0, w_maxn} + (DLY_W+1)'(2);
          end
        end
        FLUSH: begin
          if (r_fcnt == (DLY_W+1)'(1)) begin
            r_state <= IDLE;
            r_ena   <= 1'b1;
            r_busy  <= 1'b0;
            r_ready <= 1'b1;
          end else begin
            r_fcnt <= r_fcnt - (DLY_W+1)'(1);
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  generate
    for (genvar g = 0; g < NE; g++) begin : g_out
      assign o_dly_active[g*DLY_W +: DLY_W] = r_active[g];
    end
  endgenerate

  assign o_cfg_ready   = r_ready;
  assign o_ena         = r_ena;
  assign o_busy        = r_busy;
  assign o_cfg_err     = r_cfg_err;
  assign o_commit_drop = r_commit_drop;
endmodule

// File: tb/tb_crpa_dly_ctrl.sv
// Bench for crpa_dly_ctrl: table-level model of shadow/active contents and
// busy-window length, plus a 6-channel instance to reach out-of-range writes.
module tb_crpa_dly_ctrl;
  localparam int NIN = 8, NT = 4, DW = 5, NE = NIN * NT;
  localparam int NIN2 = 6, NE2 = NIN2 * NT;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic            valid, commit;
  logic [2:0]      ch;
  logic [1:0]      tap;
  logic [DW-1:0]   dly;
  logic            ready, ena, busy, cerr, cdrop;
  logic [NE*DW-1:0] act;

  logic            d2_valid, d2_commit;
  logic [2:0]      d2_ch;
  logic [1:0]      d2_tap;
  logic [DW-1:0]   d2_dly;
  logic            d2_ready, d2_ena, d2_busy, d2_err, d2_drop;
  logic [NE2*DW-1:0] d2_act;

  crpa_dly_ctrl #(.Nin(NIN), .NT(NT), .DLY_W(DW)) u_dut (
    .i_clk(clk), .i_reset(rst), .i_cfg_valid(valid), .o_cfg_ready(ready),
    .i_cfg_ch(ch), .i_cfg_tap(tap), .i_cfg_dly(dly), .i_commit(commit),
    .o_dly_active(act), .o_ena(ena), .o_busy(busy), .o_cfg_err(cerr),
    .o_commit_drop(cdrop)
  );

  crpa_dly_ctrl #(.Nin(NIN2), .NT(NT), .DLY_W(DW)) u_dut2 (
    .i_clk(clk), .i_reset(rst), .i_cfg_valid(d2_valid), .o_cfg_ready(d2_ready),
    .i_cfg_ch(d2_ch), .i_cfg_tap(d2_tap), .i_cfg_dly(d2_dly), .i_commit(d2_commit),
    .o_dly_active(d2_act), .o_ena(d2_ena), .o_busy(d2_busy), .o_cfg_err(d2_err),
    .o_commit_drop(d2_drop)
  );

  int n_chk = 0, n_pass = 0;
  logic [DW-1:0] m_sh [NE];
  logic [DW-1:0] m_act [NE];

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [255:0] pack_act();
    logic [255:0] v = '0;
    for (int e = 0; e < NE; e++) v[e*DW +: DW] = m_act[e];
    return v;
  endfunction

  function automatic int max_sh();
    int m = 0;
    for (int e = 0; e < NE; e++) if (int'(m_sh[e]) > m) m = int'(m_sh[e]);
    return m;
  endfunction

  task automatic do_reset();
    rst = 1'b1; valid = 1'b0; commit = 1'b0; d2_valid = 1'b0; d2_commit = 1'b0;
    repeat (3) step();
    rst = 1'b0;
    for (int e = 0; e < NE; e++) begin m_sh[e] = '0; m_act[e] = '0; end
  endtask

  task automatic wr(input int c, input int t, input int d);
    int w = 0;
    while (!ready && w < 200) begin step(); w++; end
    if (w >= 200) chk("wr_ready_timeout", 1, 0);
    ch = 3'(c); tap = 2'(t); dly = DW'(d); valid = 1'b1;
    step();
    valid = 1'b0;
    m_sh[c*NT + t] = DW'(d);
  endtask

  // Pulses commit, then tracks the busy window. Optional: a second commit
  // (and a held write) injected drop_at cycles into the window.
  task automatic commit_run(input string tag, input int drop_at, input bit hold_wr);
    int len, cnt;
    bit bad;
    len = NE + max_sh() + 2;
    for (int e = 0; e < NE; e++) m_act[e] = m_sh[e];
    commit = 1'b1;
    step();
    commit = 1'b0;
    valid = 1'b0;
    cnt = 0; bad = 1'b0;
    while (busy && cnt < 300) begin
      if (ena !== 1'b0 || ready !== 1'b0) bad = 1'b1;
      if (cnt == drop_at) begin commit = 1'b1; if (hold_wr) valid = 1'b1; end
      step();
      cnt++;
      if (drop_at >= 0 && cnt == drop_at + 1) begin
        commit = 1'b0;
        chk({tag, "_drop"}, cdrop, 1);
      end
    end
    chk({tag, "_len"}, cnt, len);
    chk({tag, "_ena_win"}, bad, 0);
    chk({tag, "_ena_end"}, {ena, ready}, 2'b11);
    chk({tag, "_act"}, act, pack_act());
  endtask

  initial begin
    int cnt;
    logic [255:0] v;
    do_reset();
    // 1: reset state and all-zero commit
    chk("rst_ctl", {ena, ready, busy, cerr, cdrop}, 5'b11000);
    chk("rst_act", act, 0);
    commit_run("zero", -1, 0);

    // 2: single write, commit next cycle (32+17+2)
    wr(3, 2, 17);
    commit_run("t2", -1, 0);
    chk("t2_entry", act[(3*NT+2)*DW +: DW], 17);

    // 3: write in the commit cycle
    do_reset();
    ch = 3'd5; tap = 2'd1; dly = 5'd9; valid = 1'b1;
    m_sh[21] = 5'd9;
    commit_run("t3", -1, 0);
    chk("t3_entry", act[21*DW +: DW], 9);

    // 4: commit during COPY dropped, held write waits for IDLE
    ch = 3'd6; tap = 2'd3; dly = 5'd25; valid = 1'b0;
    commit_run("t4", 10, 1);
    step();
    valid = 1'b0;
    m_sh[27] = 5'd25;
    chk("t4_act_unchanged", act, pack_act());
    commit_run("t4b", -1, 0);

    // 5: out-of-range channel on 6-channel instance
    d2_ch = 3'd7; d2_tap = 2'd0; d2_dly = 5'd5; d2_valid = 1'b1;
    step();
    d2_valid = 1'b0;
    chk("t5_err", d2_err, 1);
    d2_ch = 3'd2; d2_tap = 2'd1; d2_dly = 5'd3; d2_valid = 1'b1;
    step();
    d2_valid = 1'b0;
    chk("t5_err_clear", d2_err, 0);
    d2_commit = 1'b1;
    step();
    d2_commit = 1'b0;
    cnt = 0;
    while (d2_busy && cnt < 300) begin step(); cnt++; end
    chk("t5_len", cnt, NE2 + 3 + 2);
    v = '0; v[(2*NT+1)*DW +: DW] = 5'd3;
    chk("t5_act", d2_act, v);

    // 6: reset during COPY after loading all 31
    for (int e = 0; e < NE; e++) wr(e / NT, e % NT, 31);
    commit = 1'b1; step(); commit = 1'b0;
    repeat (20) step();
    rst = 1'b1; step(); rst = 1'b0;
    for (int e = 0; e < NE; e++) begin m_sh[e] = '0; m_act[e] = '0; end
    chk("t6_rst", {ena, ready, busy}, 3'b110);
    chk("t6_act", act, 0);
    for (int e = 0; e < NE; e++) wr(e / NT, e % NT, 31);
    commit_run("t6_all31", -1, 0);

    // random rounds
    for (int r = 0; r < 6; r++) begin
      int k = $urandom_range(1, 12);
      for (int i = 0; i < k; i++)
        wr($urandom_range(0, NIN-1), $urandom_range(0, NT-1), $urandom_range(0, 31));
      chk("rnd_err", cerr, 0);
      if ($urandom_range(0, 1) == 1) begin
        int c = $urandom_range(0, NIN-1), t = $urandom_range(0, NT-1), d = $urandom_range(0, 31);
        ch = 3'(c); tap = 2'(t); dly = DW'(d); valid = 1'b1;
        m_sh[c*NT + t] = DW'(d);
      end
      commit_run($sformatf("rnd%0d", r), -1, 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
